lv_reg_arb: RTL

LV_REG_ARB -- requirements
Module: lv_reg_arb

---
 rtl/lv_reg_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lv_reg_arb.sv
// lv_reg_arb: two-requester register-bus arbiter.
//   Requester 0 is the SPI front end and requester 1 is the internal
//   sequencer. The block arbitrates round-robin, issues one write or read
//   strobe to the register slave, and for reads returns the slave's data
//   and status to the requester that owns the transaction.
//
// Ports
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_req_ren/wen [1:0]    per-requester read / write request
//   i_req_addr/wdata       per-requester address / write data, slice k = requester k
//   o_req_gnt [1:0]        one-cycle pulse: request accepted
//   o_req_rack [1:0]       one-cycle pulse: read response valid
//   o_req_rstatus          1 = read timed out (or slave error), qualified by o_req_rack
//   o_req_rdata            read data, qualified by o_req_rack, held between acks
//   o_reg_ren/wen          single-cycle strobes to the register slave
//   o_reg_addr/wdata       registered address / data to the register slave
//   i_reg_rack/rstatus/rdata  read return from the register slave
//
// Build option
//   LV_REG_ARB_TMO_EN  when defined, a read waiting longer than TMO_CYC
//                      cycles for the slave ack is completed with
//                      o_req_rstatus=1 and o_req_rdata=0.
//
// state | meaning
// IDLE  | waiting for a request; latches winner, addr and wdata on accept
// WR    | write strobe and grant to the winner for one cycle
// RD    | read strobe and grant to the winner for one cycle
// WAIT  | waiting for the slave read ack (or timeout)

module lv_reg_arb #(
  parameter int REG_AW  = 7,
  parameter int REG_DW  = 8,
  parameter int TMO_CYC = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_ren,
  input  logic [1:0]          i_req_wen,
  input  logic [2*REG_AW-1:0] i_req_addr,
  input  logic [2*REG_DW-1:0] i_req_wdata,
  output logic [1:0]          o_req_gnt,
  output logic [1:0]          o_req_rack,
  output logic                o_req_rstatus,
  output logic [REG_DW-1:0]   o_req_rdata,
  output logic                o_reg_ren,
  output logic                o_reg_wen,
  output logic [REG_AW-1:0]   o_reg_addr,
  output logic [REG_DW-1:0]   o_reg_wdata,
  input  logic                i_reg_rack,
  input  logic                i_reg_rstatus,
  input  logic [REG_DW-1:0]   i_reg_rdata
);

  if (TMO_CYC < 4 || TMO_CYC > 255) begin : g_bad_tmo_cyc
    $error("lv_reg_arb: TMO_CYC must be in 4..255");
  end

  typedef enum logic [1:0] {IDLE, WR, RD, WAIT} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   ptr_last;
  logic   tmo_hit;
  logic [1:0] req_v;
  logic   win;
  logic   win_rd;

  assign req_v = i_req_ren | i_req_wen;

  // On a tie the requester that was not granted last wins; otherwise the
  // sole requester wins.
  always_comb begin
    win = 1'b0;
    if (req_v == 2'b11) win = ~ptr_last;
    else                win = req_v[1];
  end

  // A requester raising ren and wen together is served as a read.
  assign win_rd = win ? i_req_ren[1] : i_req_ren[0];

`ifdef LV_REG_ARB_TMO_EN
  logic [7:0] tmo_cnt;

  assign tmo_hit = (state == WAIT) && (tmo_cnt == 8'(TMO_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                         tmo_cnt <= '0;
    else if (state == WAIT && !i_reg_rack && !tmo_hit)    tmo_cnt <= tmo_cnt + 8'd1;
    else                                                  tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_v) state_nxt = win_rd ? RD : WR;
      WR:      state_nxt = IDLE;
      RD:      state_nxt = WAIT;
      WAIT:    if (i_reg_rack || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_gnt = 2'b00;
    o_reg_wen = 1'b0;
    o_reg_ren = 1'b0;
    case (state)
      WR: begin
        o_reg_wen = 1'b1;
        o_req_gnt = {owner, ~owner};
      end
      RD: begin
        o_reg_ren = 1'b1;
        o_req_gnt = {owner, ~owner};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      owner         <= 1'b0;
      ptr_last      <= 1'b1;
      o_reg_addr    <= '0;
      o_reg_wdata   <= '0;
      o_req_rack    <= 2'b00;
      o_req_rdata   <= '0;
      o_req_rstatus <= 1'b0;
    end else begin
      o_req_rack <= 2'b00;
      if (state == IDLE && |req_v) begin
        owner       <= win;
        ptr_last    <= win;
        o_reg_addr  <= win ? i_req_addr[2*REG_AW-1:REG_AW]   : i_req_addr[REG_AW-1:0];
        o_reg_wdata <= win ? i_req_wdata[2*REG_DW-1:REG_DW] : i_req_wdata[REG_DW-1:0];
      end
      if (state == WAIT) begin
        // A real ack arriving on the last counted cycle beats the timeout.
        if (i_reg_rack) begin
          o_req_rack    <= {owner, ~owner};
          o_req_rdata   <= i_reg_rdata;
          o_req_rstatus <= i_reg_rstatus;
        end else if (tmo_hit) begin
          o_req_rack    <= {owner, ~owner};
          o_req_rdata   <= '0;
          o_req_rstatus <= 1'b1;
        end
      end
    end
  end

endmodule
